// File: rtl/handshake_protocol_monitor.sv
// Passive ready/valid protocol monitor: per-channel transfer counters and sticky
// error flags. Define HANDSHAKE_MONITOR_ASSERT_EN to add concurrent assertions.
module handshake_protocol_monitor #(
   parameter int NUM_CH  = 3,
   parameter int DATA_W  = 4,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                     CLK,
   input  logic                     ASYNCRESET,
   input  logic                     clear,
   input  logic [NUM_CH-1:0]        valid,
   input  logic [NUM_CH-1:0]        ready,
   input  logic [NUM_CH*DATA_W-1:0] data,
   output logic [NUM_CH*CNT_W-1:0]  xfer_count,
   output logic [NUM_CH-1:0]        err_valid_drop,
   output logic [NUM_CH-1:0]        err_data_change,
   output logic [NUM_CH-1:0]        err_timeout,
   output logic                     any_error
);

   localparam int SAT = (TIMEOUT > 0) ? TIMEOUT : 1;
   localparam int SCW = $clog2(SAT + 1);

   typedef enum logic {IDLE, STALL} state_t;

   logic [NUM_CH-1:0] vd_nxt, dc_nxt, to_nxt;
   logic [NUM_CH-1:0] vd_q, dc_q, to_q;
   logic              any_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t            state;
      logic [DATA_W-1:0] cap;
      logic [SCW-1:0]    stall_cnt;
      logic [CNT_W-1:0]  cnt;
      logic              vd_r, dc_r, to_r;
      logic              v, r, xfer, stalled, drop_ev, dchg_ev, to_ev;
      logic [DATA_W-1:0] d;

      assign v       = valid[i];
      assign r       = ready[i];
      assign d       = data[i*DATA_W +: DATA_W];
      assign xfer    = v & r;
      assign stalled = v & ~r;
      assign drop_ev = (state == STALL) & ~v;
      assign dchg_ev = (state == STALL) & v & (d != cap);

      // Fires only on the transition into TIMEOUT; the saturated count cannot re-arm it.
      if (TIMEOUT > 0) begin : g_to
         assign to_ev = stalled & ((state == IDLE) ? (SAT == 1)
                                                   : (stall_cnt == SCW'(SAT - 1)));
      end else begin : g_no_to
         assign to_ev = 1'b0;
      end

      // Event wins over clear, so a same-cycle event leaves its bit set.
      assign vd_nxt[i] = drop_ev | (vd_r & ~clear);
      assign dc_nxt[i] = dchg_ev | (dc_r & ~clear);
      assign to_nxt[i] = to_ev   | (to_r & ~clear);

      always_ff @(posedge CLK or posedge ASYNCRESET) begin
         if (ASYNCRESET) begin
            state     <= IDLE;
            cap       <= '0;
            stall_cnt <= '0;
            cnt       <= '0;
            vd_r      <= 1'b0;
            dc_r      <= 1'b0;
            to_r      <= 1'b0;
         end else begin
            vd_r <= vd_nxt[i];
            dc_r <= dc_nxt[i];
            to_r <= to_nxt[i];
            if (clear)
               cnt <= '0;
            else if (xfer)
               cnt <= cnt + CNT_W'(1);
            case (state)
               IDLE: begin
                  if (stalled) begin
                     state     <= STALL;
                     cap       <= d;
                     stall_cnt <= SCW'(1);
                  end
               end
               STALL: begin
                  if (!v || r) begin
                     state     <= IDLE;
                     stall_cnt <= '0;
                  end else if (stall_cnt != SCW'(SAT)) begin
                     stall_cnt <= stall_cnt + SCW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign vd_q[i] = vd_r;
      assign dc_q[i] = dc_r;
      assign to_q[i] = to_r;
      assign xfer_count[i*CNT_W +: CNT_W] = cnt;

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
      a_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET) stalled |=> v)
         else $error("handshake monitor: valid dropped while stalled on channel %0d", i);
      a_stable: assert property (@(posedge CLK) disable iff (ASYNCRESET) stalled |=> $stable(d))
         else $error("handshake monitor: payload changed while stalled on channel %0d", i);
      if (TIMEOUT > 0) begin : g_to_assert
         a_tmo: assert property (@(posedge CLK) disable iff (ASYNCRESET)
                                 stalled [*TIMEOUT] |=> !stalled)
            else $error("handshake monitor: stall timeout on channel %0d", i);
      end
`endif
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET)
         any_q <= 1'b0;
      else
         any_q <= |(vd_nxt | dc_nxt | to_nxt);
   end

   assign err_valid_drop  = vd_q;
   assign err_data_change = dc_q;
   assign err_timeout     = to_q;
   assign any_error       = any_q;

endmodule
